// File: rtl/sequenciador_pc_if.sv
// Instruction-fetch bus between the PC sequencer (master) and instruction memory (slave).
interface sequenciador_pc_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_endereco;
  logic             instr_valida;

  modport master (output mem_req, output mem_endereco, output instr_valida, input mem_ack);
  modport slave  (input mem_req, input mem_endereco, input instr_valida, output mem_ack);
endinterface

// File: rtl/sequenciador_pc.sv
// PC register and fetch sequencer: fetch handshake, phase counting, sequential/branch load.
// Define SEQ_PC_SOMA_INTERNA_EN to compute the next address internally as estado_pc+1.
//
// state   | meaning
// BUSCA   | fetch request outstanding (or being raised), fase held at 0
// EXECUTA | instruction window running, fase counts up to FASES-1
// PARADO  | halted, PC held, no fetch until halt drops
module sequenciador_pc #(
  parameter int               WIDTH    = 32,
  parameter int               FASES    = 10,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     endereco_soma,
  input  logic [WIDTH-1:0]     desvio_alvo,
  input  logic                 desvio,
  input  logic                 halt,
  sequenciador_pc_if.master    mem,
  output logic [WIDTH-1:0]     estado_pc,
  output logic [3:0]           fase,
  output logic                 parado
);

  localparam logic [1:0] BUSCA   = 2'd0;
  localparam logic [1:0] EXECUTA = 2'd1;
  localparam logic [1:0] PARADO  = 2'd2;
  localparam logic [3:0] ULTIMA  = 4'(FASES - 1);

  logic [1:0]       estado_q, estado_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [3:0]       fase_q, fase_d;
  logic             req_q, req_d;
  logic             valida_q, valida_d;
  logic             parado_q, parado_d;
  logic [WIDTH-1:0] proximo;

`ifdef SEQ_PC_SOMA_INTERNA_EN
  logic unused_soma;
  assign unused_soma = ^endereco_soma;
  assign proximo     = pc_q + WIDTH'(1);
`else
  assign proximo     = endereco_soma;
`endif

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    fase_d   = fase_q;
    req_d    = req_q;
    valida_d = 1'b0;
    parado_d = parado_q;
    case (estado_q)
      BUSCA: begin
        fase_d   = 4'd0;
        parado_d = 1'b0;
        // Request is only low here on the first cycle after reset
        if (!req_q) begin
          req_d = 1'b1;
        end else if (mem.mem_ack) begin
          req_d    = 1'b0;
          valida_d = 1'b1;
          fase_d   = 4'd1;
          estado_d = EXECUTA;
        end
      end
      EXECUTA: begin
        if (fase_q == ULTIMA) begin
          pc_d   = desvio ? desvio_alvo : proximo;
          fase_d = 4'd0;
          if (halt) begin
            estado_d = PARADO;
            parado_d = 1'b1;
            req_d    = 1'b0;
          end else begin
            // Raise the next request on the same edge so a zero-wait window is exactly FASES cycles
            estado_d = BUSCA;
            req_d    = 1'b1;
          end
        end else begin
          fase_d = fase_q + 4'd1;
        end
      end
      PARADO: begin
        fase_d   = 4'd0;
        req_d    = 1'b0;
        parado_d = 1'b1;
        if (!halt) begin
          estado_d = BUSCA;
          parado_d = 1'b0;
          req_d    = 1'b1;
        end
      end
      default: begin
        estado_d = BUSCA;
        fase_d   = 4'd0;
        req_d    = 1'b0;
        parado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= BUSCA;
      pc_q     <= RESET_PC;
      fase_q   <= 4'd0;
      req_q    <= 1'b0;
      valida_q <= 1'b0;
      parado_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      fase_q   <= fase_d;
      req_q    <= req_d;
      valida_q <= valida_d;
      parado_q <= parado_d;
    end
  end

  assign estado_pc        = pc_q;
  assign fase             = fase_q;
  assign parado           = parado_q;
  assign mem.mem_req      = req_q;
  assign mem.mem_endereco = pc_q;
  assign mem.instr_valida = valida_q;

endmodule
